// File: rtl/fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctrl
// Brief    : Sequencer for an in-place radix-2 DIT FFT/IFFT. It walks LOG2N
//            stages of N/2 butterflies and issues sample-RAM read addresses,
//            twiddle ROM addresses and one-cycle-delayed write-back addresses.
//            A single DRAIN cycle separates stages, so the last write of a
//            stage lands before the next stage reads.
// Revision : 1.0 - initial release
// ============================================================================
module fft_ctrl #(
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             fft_ifft_i,
  output logic             fft_ifft_o,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage_o,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr0,
  output logic [LOG2N-1:0] wr_addr1
);

  // Butterfly counter is one bit narrower than an address (k < N/2).
  localparam int c_KW = LOG2N - 1;
  // Stage counter only needs enough bits to hold LOG2N-1.
  localparam int c_SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;
  localparam logic [c_KW-1:0] c_K_LAST = {c_KW{1'b1}};
  localparam logic [c_SW-1:0] c_S_LAST = c_SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_KW-1:0]   r_k;
  logic [c_SW-1:0]   r_s;

  state_t            w_nxt_state;
  logic [c_KW-1:0]   w_nxt_k;
  logic [c_SW-1:0]   w_nxt_s;
  logic              w_accept;
  logic              w_nxt_run;
  logic              w_nxt_busy;

  logic [LOG2N-1:0]  w_k_ext;
  logic [LOG2N-1:0]  w_span;
  logic [LOG2N-1:0]  w_pos;
  logic [LOG2N-1:0]  w_addr0;
  logic [LOG2N-1:0]  w_addr1;
  logic [c_SW:0]     w_tw_shift;
  logic [c_KW-1:0]   w_tw;

  // Next-state and counter sequencing; abort overrides every state, including
  // a simultaneous start in IDLE.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_k     = r_k;
    w_nxt_s     = r_s;
    w_accept    = 1'b0;
    if (abort) begin
      w_nxt_state = ST_IDLE;
      w_nxt_k     = '0;
      w_nxt_s     = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_nxt_state = ST_RUN;
            w_nxt_k     = '0;
            w_nxt_s     = '0;
            w_accept    = 1'b1;
          end
        end
        ST_RUN: begin
          if (r_k == c_K_LAST) begin
            w_nxt_state = ST_DRAIN;
            w_nxt_k     = '0;
          end else begin
            w_nxt_k = r_k + c_KW'(1);
          end
        end
        ST_DRAIN: begin
          if (r_s == c_S_LAST) begin
            w_nxt_state = ST_DONE;
          end else begin
            w_nxt_state = ST_RUN;
            w_nxt_s     = r_s + c_SW'(1);
            w_nxt_k     = '0;
          end
        end
        ST_DONE: begin
          w_nxt_state = ST_IDLE;
          w_nxt_s     = '0;
          w_nxt_k     = '0;
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_k     = '0;
          w_nxt_s     = '0;
        end
      endcase
    end
  end

  // Butterfly address generation for the upcoming (k, s). Clearing the low s
  // bits of k and doubling gives grp*2*span without a variable s+1 shift.
  always_comb begin
    w_nxt_run  = (w_nxt_state == ST_RUN);
    w_nxt_busy = (w_nxt_state == ST_RUN) || (w_nxt_state == ST_DRAIN);
    w_k_ext    = {1'b0, w_nxt_k};
    w_span     = LOG2N'(1) << w_nxt_s;
    w_pos      = w_k_ext & (w_span - LOG2N'(1));
    w_addr0    = ((w_k_ext & ~(w_span - LOG2N'(1))) << 1) | w_pos;
    w_addr1    = w_addr0 | w_span;
    w_tw_shift = (c_SW + 1)'(c_KW) - {1'b0, w_nxt_s};
    w_tw       = w_pos[c_KW-1:0] << w_tw_shift;
  end

  // State, counters and all outputs registered from the next-state values;
  // the write port is the read port delayed by one cycle, killed on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_s        <= '0;
      fft_ifft_o <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stage_o    <= '0;
      rd_en      <= 1'b0;
      rd_addr0   <= '0;
      rd_addr1   <= '0;
      tw_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr0   <= '0;
      wr_addr1   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_k     <= w_nxt_k;
      r_s     <= w_nxt_s;
      if (w_accept) begin
        fft_ifft_o <= fft_ifft_i;
      end
      busy     <= w_nxt_busy;
      done     <= (w_nxt_state == ST_DONE);
      stage_o  <= w_nxt_busy ? LOG2N'(w_nxt_s) : '0;
      rd_en    <= w_nxt_run;
      rd_addr0 <= w_nxt_run ? w_addr0 : '0;
      rd_addr1 <= w_nxt_run ? w_addr1 : '0;
      tw_addr  <= w_nxt_run ? w_tw : '0;
      wr_en    <= rd_en & ~abort;
      wr_addr0 <= rd_addr0;
      wr_addr1 <= rd_addr1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_ctrl
// Brief    : Bench for fft_ctrl. A cycle-count model derives every expected
//            output from the position inside a run; directed runs cover the
//            reference timing, ignored starts, abort and mid-run reset, then
//            a randomized start/abort/mode stream follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_ctrl;

  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int HALF  = N / 2;
  localparam int P     = HALF + 1;
  localparam int TOTAL = LOG2N * P;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             fft_ifft_i;
  logic             fft_ifft_o;
  logic             busy;
  logic             done;
  logic [LOG2N-1:0] stage_o;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr0;
  logic [LOG2N-1:0] rd_addr1;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr0;
  logic [LOG2N-1:0] wr_addr1;

  fft_ctrl #(.LOG2N(LOG2N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .fft_ifft_i (fft_ifft_i),
    .fft_ifft_o (fft_ifft_o),
    .busy       (busy),
    .done       (done),
    .stage_o    (stage_o),
    .rd_en      (rd_en),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .tw_addr    (tw_addr),
    .wr_en      (wr_en),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: m_t is the cycle number inside a run (0 = not running).
  int m_t;
  bit m_mode;
  bit p_rd;
  int p_a0, p_a1;
  bit e_busy, e_done, e_rd, e_wr;
  int e_stage, e_a0, e_a1, e_tw, e_wa0, e_wa1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_mode = 1'b0;
    p_rd   = 1'b0;
    p_a0   = 0;
    p_a1   = 0;
  endtask

  // Advance the model by one clock edge using the inputs held before it.
  task automatic model_edge();
    int idx, span, grp, pos;
    e_wr  = p_rd && !abort;
    e_wa0 = p_a0;
    e_wa1 = p_a1;
    if (abort) m_t = 0;
    else if (m_t == 0) begin
      if (start) begin
        m_t    = 1;
        m_mode = fft_ifft_i;
      end
    end else if (m_t == TOTAL + 1) m_t = 0;
    else m_t++;
    e_busy  = (m_t >= 1) && (m_t <= TOTAL);
    e_done  = (m_t == TOTAL + 1);
    e_rd    = 1'b0;
    e_stage = 0;
    e_a0 = 0; e_a1 = 0; e_tw = 0;
    if (e_busy) begin
      e_stage = (m_t - 1) / P;
      idx     = (m_t - 1) % P;
      if (idx < HALF) begin
        e_rd = 1'b1;
        span = 2 ** e_stage;
        grp  = idx / span;
        pos  = idx % span;
        e_a0 = grp * 2 * span + pos;
        e_a1 = e_a0 + span;
        e_tw = pos * (2 ** (LOG2N - 1 - e_stage));
      end
    end
    p_rd = e_rd;
    p_a0 = e_a0;
    p_a1 = e_a1;
  endtask

  task automatic check_outputs();
    check_val("busy", busy, e_busy);
    check_val("done", done, e_done);
    check_val("rd_en", rd_en, e_rd);
    check_val("wr_en", wr_en, e_wr);
    check_val("stage_o", stage_o, e_stage);
    check_val("fft_ifft_o", fft_ifft_o, m_mode);
    if (e_rd) begin
      check_val("rd_addr0", rd_addr0, e_a0);
      check_val("rd_addr1", rd_addr1, e_a1);
      check_val("tw_addr", tw_addr, e_tw);
    end
    if (e_wr) begin
      check_val("wr_addr0", wr_addr0, e_wa0);
      check_val("wr_addr1", wr_addr1, e_wa1);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_rd_en"}, rd_en, 0);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_stage"}, stage_o, 0);
    check_val({tag, "_mode"}, fft_ifft_o, 0);
    check_val({tag, "_rd_addr0"}, rd_addr0, 0);
    check_val({tag, "_rd_addr1"}, rd_addr1, 0);
    check_val({tag, "_tw_addr"}, tw_addr, 0);
    check_val({tag, "_wr_addr0"}, wr_addr0, 0);
    check_val({tag, "_wr_addr1"}, wr_addr1, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Full run started in cycle 0, with optional stray starts in cycles 5, 20.
  task automatic run_directed(input bit mode, input bit pulses);
    int done_cnt, done_cyc;
    done_cnt   = 0;
    done_cyc   = -1;
    start      = 1'b1;
    fft_ifft_i = mode;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start      = pulses && (c == 5 || c == 20);
      fft_ifft_i = ~mode;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 1) begin
        check_val("c1_rd_addr0", rd_addr0, 0);
        check_val("c1_rd_addr1", rd_addr1, 1);
      end
      if (c == 9) begin
        check_val("c9_rd_en", rd_en, 0);
        check_val("c9_wr_en", wr_en, 1);
        check_val("c9_wr_addr0", wr_addr0, 14);
        check_val("c9_wr_addr1", wr_addr1, 15);
      end
      if (c == 24) begin
        check_val("s2k5_a0", rd_addr0, 9);
        check_val("s2k5_a1", rd_addr1, 13);
        check_val("s2k5_tw", tw_addr, 2);
      end
      if (c == 31) begin
        check_val("s3k3_a0", rd_addr0, 3);
        check_val("s3k3_a1", rd_addr1, 11);
        check_val("s3k3_tw", tw_addr, 3);
      end
      if (c == 36) check_val("c36_busy", busy, 1);
    end
    check_val("done_count", done_cnt, 1);
    check_val("done_cycle", done_cyc, 37);
  endtask

  initial begin
    int done_cnt;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    fft_ifft_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Reference run with ignored start pulses.
    run_directed(1'b0, 1'b1);

    // Abort during stage 1, then a clean rerun.
    done_cnt = 0;
    start    = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      start = 1'b0;
      abort = (c == 12);
      if (done) done_cnt++;
      if (c == 13) begin
        check_val("abort_rd_en", rd_en, 0);
        check_val("abort_wr_en", wr_en, 0);
        check_val("abort_busy", busy, 0);
      end
    end
    check_val("abort_done_count", done_cnt, 0);
    run_directed(1'b0, 1'b0);

    // Simultaneous start and abort in IDLE must stay idle.
    start      = 1'b1;
    abort      = 1'b1;
    fft_ifft_i = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_val("start_abort_busy", busy, 0);
    repeat (2) tick();

    // Asynchronous reset in cycle 20 of a run.
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("held_reset");
    rst_n = 1'b1;
    run_directed(1'b1, 1'b0);

    // Randomized start/abort/mode stream.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 40) == 0);
      fft_ifft_i = $urandom_range(0, 1);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter LOG2N, default 4, meaning log2 of FFT size N (N = 2^LOG2N, LOG2N >= 2).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to run one complete in-place radix-2 DIT FFT; honoured only in IDLE.
REQ-005 abort  input  1  synchronous abort; returns the block to IDLE from any state.
REQ-006 fft_ifft_i  input  1  mode sampled with accepted start: 0 FFT, 1 IFFT.
REQ-007 fft_ifft_o  output  1  latched mode driven to the butterfly datapath; constant for the whole run.
REQ-008 busy  output  1  high in RUN and DRAIN.
REQ-009 done  output  1  single-cycle pulse on completion of the final stage.
REQ-010 stage_o  output  LOG2N bits (zero-extended; the stage index needs only ceil(log2(LOG2N)) bits)  current stage index.
REQ-011 rd_en  output  1  read strobe to the sample RAM (synchronous read, 1-cycle latency).
REQ-012 rd_addr0, rd_addr1  output  LOG2N each  butterfly input pair addresses.
REQ-013 tw_addr  output  LOG2N-1  twiddle ROM address.
REQ-014 wr_en  output  1  write-back strobe for the butterfly outputs.
REQ-015 wr_addr0, wr_addr1  output  LOG2N each  write-back addresses for out0 and out1.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE, start=1 SHALL latch fft_ifft_i, clear the stage and butterfly counters, and enter RUN on the next cycle.
REQ-018 In RUN, rd_en SHALL be high each cycle for butterfly index k = 0..N/2-1 of stage s, with k incrementing each cycle.
REQ-019 Address generation SHALL use span = 2^s, grp = k>>s and pos = k & (span-1).
REQ-020 Addresses SHALL be rd_addr0 = grp*2*span + pos, rd_addr1 = rd_addr0 + span and tw_addr = pos << (LOG2N-1-s).
REQ-021 After k = N/2-1, RUN SHALL go to DRAIN for exactly one cycle, with rd_en low in DRAIN.
REQ-022 From DRAIN, the FSM SHALL go to DONE if s = LOG2N-1; otherwise it SHALL increment s, reset k to 0 and return to RUN.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 wr_en, wr_addr0 and wr_addr1 SHALL equal rd_en, rd_addr0 and rd_addr1 delayed by exactly one cycle.
REQ-025 The DRAIN cycle SHALL guarantee that the last write of stage s commits before the first read of stage s+1.
REQ-026 Run length SHALL be LOG2N*(N/2 + 1) busy cycles, and done SHALL follow in the next cycle.
REQ-027 start in RUN, DRAIN or DONE SHALL be ignored, with no restart and no second done.
REQ-028 abort=1 in any state SHALL force IDLE on the next cycle.
REQ-029 On abort, rd_en and wr_en SHALL be 0 from the next cycle (pending write suppressed), done SHALL not pulse, and fft_ifft_o is held.
REQ-030 Simultaneous abort and start in IDLE: abort SHALL win and the block SHALL stay in IDLE.
REQ-031 fft_ifft_o and stage_o SHALL be stable while busy; stage_o SHALL equal 0 outside a run.

Reset
REQ-032 While rst_n=0, the state SHALL be IDLE and all counters 0.
REQ-033 While rst_n=0, every output (busy, done, rd_en, wr_en, all addresses, stage_o, fft_ifft_o) SHALL be 0, asynchronously.
REQ-034 Reset asserted mid-run SHALL abandon the run: no write, no done, and the next start begins at stage 0.

Verification
REQ-035 LOG2N=4, start with fft_ifft_i=0 in cycle 0 -> required response:
- rd_en in cycles 1-8, stage 0 pairs (0,1),(2,3)..(14,15), tw_addr=0;
- DRAIN in cycles 9, 18, 27 and 36;
- done=1 only in cycle 37, busy=1 in cycles 1-36.
REQ-036 Stage 2, k=5 -> rd_addr0=9, rd_addr1=13, tw_addr=2; stage 3, k=3 -> (3,11), tw_addr=3.
REQ-037 Write pipeline check -> wr_addr in cycle t+1 equals rd_addr in cycle t, and in cycle 9 wr_en=1 with (14,15) while rd_en=0.
REQ-038 start pulsed in cycles 5 and 20 of a run -> ignored, exactly one done in cycle 37.
REQ-039 abort in cycle 12 (stage 1) -> rd_en=wr_en=0 from cycle 13 and no done; a new start then reproduces REQ-035 timing.
REQ-040 rst_n low in cycle 20 -> all outputs 0 immediately; after release, start with fft_ifft_i=1 -> fft_ifft_o=1 for the entire run.
